// File: rtl/psx_pad_if.sv
// psx_pad_if: PSX pad serial link; the host drives att_n/psx_clk/cmd, the pad answers on dat/ack_n
interface psx_pad_if;
    logic att_n;
    logic psx_clk;
    logic cmd;
    logic dat_out;
    logic dat_oe;
    logic ack_n;
    modport master (output att_n, psx_clk, cmd, input dat_out, dat_oe, ack_n);
    modport slave (input att_n, psx_clk, cmd, output dat_out, dat_oe, ack_n);
endinterface

// File: rtl/psx_pad_responder.sv
// psx_pad_responder: device end of the PSX pad link, answering polls with ID, 5A and button bytes
// Define PSX_ANALOG_EN for the analog pad (ID 8'h73, four stick bytes after the buttons).
module psx_pad_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_DELAY = 40,
    parameter int ACK_WIDTH = 20,
    parameter logic [7:0] PAD_ID = 8'h41
) (
    input  logic clk,
    input  logic rst,
    psx_pad_if.slave pad,
    input  logic [15:0] buttons,
`ifdef PSX_ANALOG_EN
    input  logic [7:0] stick_rx,
    input  logic [7:0] stick_ry,
    input  logic [7:0] stick_lx,
    input  logic [7:0] stick_ly,
`endif
    output logic [7:0] cmd_byte,
    output logic cmd_valid,
    output logic [3:0] byte_idx,
    output logic busy,
    output logic err_f
);
`ifdef PSX_ANALOG_EN
    localparam logic [3:0] LAST_IDX = 4'd8;
    localparam logic [7:0] ID = 8'h73;
`else
    localparam logic [3:0] LAST_IDX = 4'd4;
    localparam logic [7:0] ID = PAD_ID;
`endif
    localparam int ACK_MAX = ACK_DELAY > ACK_WIDTH ? ACK_DELAY : ACK_WIDTH;
    localparam int ACW = $clog2(ACK_MAX + 1);
    typedef enum logic [2:0] {IDLE, SHIFT, ACK_WAIT, ACK_PULSE, DONE, IGNORE} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] att_sync_q, att_sync_d, clk_sync_q, clk_sync_d, cmd_sync_q, cmd_sync_d;
    logic att_p_q, att_p_d, clk_p_q, clk_p_d;
    logic [7:0] tx_q, tx_d, cmd_byte_q, cmd_byte_d;
    logic [6:0] rx_q, rx_d;
    logic [3:0] bit_cnt_q, bit_cnt_d, byte_idx_q, byte_idx_d;
    logic [ACW-1:0] ack_cnt_q, ack_cnt_d;
    logic [15:0] btn_q, btn_d;
    logic dat_oe_q, dat_oe_d, ack_n_q, ack_n_d, cmd_valid_q, cmd_valid_d;
    logic busy_q, busy_d, err_f_q, err_f_d;
`ifdef PSX_ANALOG_EN
    logic [31:0] stk_q, stk_d;
`endif
    logic att_s, clk_s, cmd_s, att_fall, clk_rise, clk_fall;
    logic [3:0] nidx;
    logic [7:0] next_tx, rx_next;
    assign att_s = att_sync_q[SYNC_STAGES-1];
    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign cmd_s = cmd_sync_q[SYNC_STAGES-1];
    assign att_fall = att_p_q & ~att_s;
    assign clk_rise = ~clk_p_q & clk_s;
    assign clk_fall = clk_p_q & ~clk_s;
    assign rx_next = {cmd_s, rx_q};
    assign nidx = byte_idx_q + 4'd1;
    assign next_tx = nidx == 4'd1 ? ID :
                     nidx == 4'd2 ? 8'h5A :
                     nidx == 4'd3 ? btn_q[7:0] :
                     nidx == 4'd4 ? btn_q[15:8] :
`ifdef PSX_ANALOG_EN
                     nidx == 4'd5 ? stk_q[7:0] :
                     nidx == 4'd6 ? stk_q[15:8] :
                     nidx == 4'd7 ? stk_q[23:16] :
                     nidx == 4'd8 ? stk_q[31:24] :
`endif
                     8'hFF;
    always_comb begin
        att_sync_d = {att_sync_q[SYNC_STAGES-2:0], pad.att_n};
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], pad.psx_clk};
        cmd_sync_d = {cmd_sync_q[SYNC_STAGES-2:0], pad.cmd};
        att_p_d = att_s;
        clk_p_d = clk_s;
        state_d = state_q;
        tx_d = tx_q;
        rx_d = rx_q;
        bit_cnt_d = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        ack_cnt_d = ack_cnt_q;
        btn_d = btn_q;
`ifdef PSX_ANALOG_EN
        stk_d = stk_q;
`endif
        dat_oe_d = dat_oe_q;
        ack_n_d = ack_n_q;
        cmd_byte_d = cmd_byte_q;
        cmd_valid_d = 1'b0;
        busy_d = busy_q;
        err_f_d = err_f_q;
        if (att_s) begin
            state_d = IDLE;
            dat_oe_d = 1'b0;
            ack_n_d = 1'b1;
            busy_d = 1'b0;
            bit_cnt_d = 4'd0;
            byte_idx_d = 4'd0;
        end else begin
            case (state_q)
                IDLE: if (att_fall) begin
                    tx_d = 8'hFF;
                    btn_d = buttons;
`ifdef PSX_ANALOG_EN
                    stk_d = {stick_ly, stick_lx, stick_ry, stick_rx};
`endif
                    dat_oe_d = 1'b1;
                    busy_d = 1'b1;
                    byte_idx_d = 4'd0;
                    bit_cnt_d = 4'd0;
                    err_f_d = 1'b0;
                    state_d = SHIFT;
                end
                SHIFT: if (clk_rise) begin
                    rx_d = rx_next[7:1];
                    bit_cnt_d = bit_cnt_q == 4'd8 ? 4'd8 : bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        cmd_byte_d = rx_next;
                        cmd_valid_d = 1'b1;
                        ack_cnt_d = '0;
                        if (byte_idx_q == 4'd0 && rx_next != 8'h01) begin
                            state_d = IGNORE;
                            dat_oe_d = 1'b0;
                            busy_d = 1'b0;
                        end else begin
                            state_d = byte_idx_q == LAST_IDX ? DONE : ACK_WAIT;
                        end
                    end
                // the falling edge before the first rising edge must not disturb bit 0
                end else if (clk_fall && bit_cnt_q != 4'd0 && bit_cnt_q < 4'd8) begin
                    tx_d = {1'b1, tx_q[7:1]};
                end
                ACK_WAIT, ACK_PULSE: if (clk_rise) begin
                    err_f_d = 1'b1;
                    ack_n_d = 1'b1;
                    dat_oe_d = 1'b0;
                    busy_d = 1'b0;
                    state_d = IGNORE;
                end else if (state_q == ACK_WAIT) begin
                    if (ack_cnt_q == ACW'(ACK_DELAY - 1)) begin
                        ack_cnt_d = '0;
                        ack_n_d = 1'b0;
                        state_d = ACK_PULSE;
                    end else begin
                        ack_cnt_d = ack_cnt_q + ACW'(1);
                    end
                end else if (ack_cnt_q == ACW'(ACK_WIDTH - 1)) begin
                    ack_n_d = 1'b1;
                    byte_idx_d = nidx;
                    bit_cnt_d = 4'd0;
                    tx_d = next_tx;
                    state_d = SHIFT;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACW'(1);
                end
                DONE: if (clk_fall) dat_oe_d = 1'b0;
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            att_sync_q <= '1;
            clk_sync_q <= '1;
            cmd_sync_q <= '0;
            att_p_q <= 1'b1;
            clk_p_q <= 1'b1;
            state_q <= IDLE;
            tx_q <= 8'hFF;
            rx_q <= '0;
            bit_cnt_q <= 4'd0;
            byte_idx_q <= 4'd0;
            ack_cnt_q <= '0;
            btn_q <= 16'hFFFF;
`ifdef PSX_ANALOG_EN
            stk_q <= '0;
`endif
            dat_oe_q <= 1'b0;
            ack_n_q <= 1'b1;
            cmd_byte_q <= 8'h00;
            cmd_valid_q <= 1'b0;
            busy_q <= 1'b0;
            err_f_q <= 1'b0;
        end else begin
            att_sync_q <= att_sync_d;
            clk_sync_q <= clk_sync_d;
            cmd_sync_q <= cmd_sync_d;
            att_p_q <= att_p_d;
            clk_p_q <= clk_p_d;
            state_q <= state_d;
            tx_q <= tx_d;
            rx_q <= rx_d;
            bit_cnt_q <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            ack_cnt_q <= ack_cnt_d;
            btn_q <= btn_d;
`ifdef PSX_ANALOG_EN
            stk_q <= stk_d;
`endif
            dat_oe_q <= dat_oe_d;
            ack_n_q <= ack_n_d;
            cmd_byte_q <= cmd_byte_d;
            cmd_valid_q <= cmd_valid_d;
            busy_q <= busy_d;
            err_f_q <= err_f_d;
        end
    end
    assign pad.dat_out = tx_q[0];
    assign pad.dat_oe = dat_oe_q;
    assign pad.ack_n = ack_n_q;
    assign cmd_byte = cmd_byte_q;
    assign cmd_valid = cmd_valid_q;
    assign byte_idx = byte_idx_q;
    assign busy = busy_q;
    assign err_f = err_f_q;
endmodule

// File: tb/tb_psx_pad_responder.sv
// tb_psx_pad_responder: host-side poller for psx_pad_responder with cmd/response scoreboards
module tb_psx_pad_responder;
    localparam int S = 2;
    localparam int AW = 20;
    localparam int H = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] buttons = 16'hFFFF;
    logic [7:0] cmd_byte;
    logic cmd_valid;
    logic [3:0] byte_idx;
    logic busy;
    logic err_f;
    psx_pad_if pad();
    psx_pad_responder dut (
        .clk(clk), .rst(rst), .pad(pad), .buttons(buttons),
        .cmd_byte(cmd_byte), .cmd_valid(cmd_valid), .byte_idx(byte_idx),
        .busy(busy), .err_f(err_f)
    );
    always #5 clk = ~clk;
    int n_checks = 0;
    int n_pass = 0;
    int ack_pulses = 0;
    int valid_cnt = 0;
    int low_cnt = 0;
    logic ack_prev = 1'b1;
    logic [7:0] cmd_q[$];
    logic [7:0] dat_q[$];
    logic [7:0] exp_cmd;
    always @(negedge clk) begin
        if (rst) begin
            low_cnt = 0;
            ack_prev = 1'b1;
        end else begin
            if (cmd_valid === 1'b1) begin
                valid_cnt++;
                n_checks++;
                if (cmd_q.size() == 0) $display("FAIL cmd_valid: unexpected strobe, cmd_byte=%h", cmd_byte);
                else begin
                    exp_cmd = cmd_q.pop_front();
                    if (cmd_byte !== exp_cmd) $display("FAIL cmd_byte: got %h expected %h", cmd_byte, exp_cmd);
                    else n_pass++;
                end
            end
            if (pad.ack_n === 1'b0) low_cnt++;
            else if (ack_prev === 1'b0) begin
                ack_pulses++;
                n_checks++;
                if (low_cnt != AW) $display("FAIL ack_width: got %0d expected %0d", low_cnt, AW);
                else n_pass++;
                low_cnt = 0;
            end
            ack_prev = pad.ack_n;
        end
    end
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic xfer_byte(input logic [7:0] c, input int chg_at, output logic [7:0] r);
        for (int i = 0; i < 8; i++) begin
            if (i == chg_at) buttons = 16'h0000;
            pad.psx_clk = 1'b0;
            pad.cmd = c[i];
            cyc(H);
            r[i] = pad.dat_out;
            pad.psx_clk = 1'b1;
            cyc(H);
        end
    endtask
    task automatic wait_ack(input string name);
        int base = ack_pulses;
        int t = 0;
        while (ack_pulses == base && t < 200) begin
            cyc(1);
            t++;
        end
        n_checks++;
        if (ack_pulses == base) $display("FAIL %s: no ack_n pulse within 200 cycles", name);
        else n_pass++;
        cyc(4);
    endtask
    task automatic run_poll(input logic [15:0] b, input bit flip);
        logic [7:0] cmds [5] = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
        logic [7:0] resp [5];
        logic [7:0] r;
        logic [7:0] e;
        resp = '{8'hFF, 8'h41, 8'h5A, b[7:0], b[15:8]};
        buttons = b;
        pad.att_n = 1'b0;
        cyc(H);
        for (int k = 0; k < 5; k++) begin
            cmd_q.push_back(cmds[k]);
            dat_q.push_back(resp[k]);
            xfer_byte(cmds[k], (flip && k == 2) ? 4 : -1, r);
            e = dat_q.pop_front();
            n_checks++;
            if (r !== e) $display("FAIL resp_byte%0d: got %h expected %h", k, r, e);
            else n_pass++;
            if (k < 4) wait_ack("poll_ack");
        end
        cyc(H);
        pad.att_n = 1'b1;
        cyc(H);
    endtask
    task automatic test_reset;
        rst = 1'b1;
        pad.att_n = 1'b1;
        pad.psx_clk = 1'b1;
        pad.cmd = 1'b0;
        cyc(4);
        n_checks++;
        if ({pad.dat_out, pad.dat_oe, pad.ack_n, cmd_byte, cmd_valid, byte_idx, busy, err_f} !== {3'b101, 8'h00, 1'b0, 4'h0, 2'b00})
            $display("FAIL reset_outputs: got dat=%b oe=%b ack=%b cmd=%h v=%b idx=%0d busy=%b err=%b",
                     pad.dat_out, pad.dat_oe, pad.ack_n, cmd_byte, cmd_valid, byte_idx, busy, err_f);
        else n_pass++;
        rst = 1'b0;
        cyc(H);
    endtask
    task automatic test_poll;
        int base_a = ack_pulses;
        int base_v = valid_cnt;
        run_poll(16'hFFFE, 1'b0);
        n_checks++;
        if (ack_pulses - base_a != 4) $display("FAIL poll_ack_count: got %0d expected 4", ack_pulses - base_a);
        else n_pass++;
        n_checks++;
        if (valid_cnt - base_v != 5) $display("FAIL poll_valid_count: got %0d expected 5", valid_cnt - base_v);
        else n_pass++;
        n_checks++;
        if (cmd_q.size() != 0) $display("FAIL poll_cmd_pending: got %0d expected 0", cmd_q.size());
        else n_pass++;
    endtask
    task automatic test_not_addressed;
        int base_a = ack_pulses;
        logic [7:0] r;
        pad.att_n = 1'b0;
        cyc(H);
        cmd_q.push_back(8'h81);
        xfer_byte(8'h81, -1, r);
        cyc(4);
        n_checks++;
        if ({pad.dat_oe, busy, err_f} !== 3'b000) $display("FAIL ignore_state: got oe=%b busy=%b err=%b expected 000", pad.dat_oe, busy, err_f);
        else n_pass++;
        xfer_byte(8'h00, -1, r);
        cyc(100);
        n_checks++;
        if (ack_pulses != base_a) $display("FAIL ignore_no_ack: got %0d pulses expected 0", ack_pulses - base_a);
        else n_pass++;
        n_checks++;
        if (err_f !== 1'b0) $display("FAIL ignore_err: got %b expected 0", err_f);
        else n_pass++;
        pad.att_n = 1'b1;
        cyc(H);
    endtask
    task automatic test_abort;
        int base_v;
        logic [7:0] r;
        pad.att_n = 1'b0;
        cyc(H);
        cmd_q.push_back(8'h01);
        xfer_byte(8'h01, -1, r);
        wait_ack("abort_ack0");
        cmd_q.push_back(8'h42);
        xfer_byte(8'h42, -1, r);
        wait_ack("abort_ack1");
        base_v = valid_cnt;
        for (int i = 0; i < 3; i++) begin
            pad.psx_clk = 1'b0;
            pad.cmd = 1'b0;
            cyc(H);
            pad.psx_clk = 1'b1;
            cyc(H);
        end
        pad.att_n = 1'b1;
        cyc(S + 1);
        n_checks++;
        if ({pad.dat_oe, busy, byte_idx} !== 6'b0) $display("FAIL abort_release: got oe=%b busy=%b idx=%0d expected 0 0 0", pad.dat_oe, busy, byte_idx);
        else n_pass++;
        cyc(20);
        n_checks++;
        if (valid_cnt != base_v) $display("FAIL abort_no_valid: got %0d strobes expected 0", valid_cnt - base_v);
        else n_pass++;
        run_poll(16'hA5C3, 1'b0);
    endtask
    task automatic test_ack_error;
        int base_a;
        logic [7:0] r;
        pad.att_n = 1'b0;
        cyc(H);
        cmd_q.push_back(8'h01);
        xfer_byte(8'h01, -1, r);
        wait_ack("err_ack0");
        cmd_q.push_back(8'h42);
        xfer_byte(8'h42, -1, r);
        base_a = ack_pulses;
        cyc(2);
        pad.psx_clk = 1'b0;
        cyc(8);
        pad.psx_clk = 1'b1;
        cyc(6);
        n_checks++;
        if ({err_f, pad.dat_oe, busy} !== 3'b100) $display("FAIL ackwait_error: got err=%b oe=%b busy=%b expected 100", err_f, pad.dat_oe, busy);
        else n_pass++;
        cyc(100);
        n_checks++;
        if (ack_pulses != base_a) $display("FAIL ackwait_no_ack: got %0d pulses expected 0", ack_pulses - base_a);
        else n_pass++;
        pad.att_n = 1'b1;
        cyc(H);
        n_checks++;
        if (err_f !== 1'b1) $display("FAIL err_sticky: got %b expected 1", err_f);
        else n_pass++;
        pad.att_n = 1'b0;
        cyc(H);
        n_checks++;
        if (err_f !== 1'b0) $display("FAIL err_clear: got %b expected 0", err_f);
        else n_pass++;
        pad.att_n = 1'b1;
        cyc(H);
    endtask
    task automatic test_snapshot;
        run_poll(16'hFFFF, 1'b1);
        run_poll(16'h0000, 1'b0);
    endtask
    task automatic test_rst_ack;
        int t = 0;
        logic [7:0] r;
        pad.att_n = 1'b0;
        cyc(H);
        cmd_q.push_back(8'h01);
        xfer_byte(8'h01, -1, r);
        while (pad.ack_n !== 1'b0 && t < 200) begin
            cyc(1);
            t++;
        end
        n_checks++;
        if (pad.ack_n !== 1'b0) $display("FAIL rst_ack_seen: got ack_n=%b expected 0", pad.ack_n);
        else n_pass++;
        cyc(5);
        rst = 1'b1;
        pad.att_n = 1'b1;
        cyc(1);
        n_checks++;
        if ({pad.dat_out, pad.dat_oe, pad.ack_n, cmd_byte, cmd_valid, byte_idx, busy, err_f} !== {3'b101, 8'h00, 1'b0, 4'h0, 2'b00})
            $display("FAIL rst_during_ack: got dat=%b oe=%b ack=%b cmd=%h v=%b idx=%0d busy=%b err=%b",
                     pad.dat_out, pad.dat_oe, pad.ack_n, cmd_byte, cmd_valid, byte_idx, busy, err_f);
        else n_pass++;
        rst = 1'b0;
        cyc(H);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        pad.att_n = 1'b1;
        pad.psx_clk = 1'b1;
        pad.cmd = 1'b0;
        test_reset();
        test_poll();
        test_not_addressed();
        test_abort();
        test_ack_error();
        test_snapshot();
        test_rst_ack();
        cyc(10);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/psx_pad_responder.md
Name: psx_pad_responder

Overview:
- Controller-side (device) end of the PSX pad serial link: it answers the host that drives ATT, CLK and CMD.
- Samples CMD, shifts the response out on DAT LSB-first and issues an ACK pulse after every byte except the last.
- Acts as a pad emulator for bench use and lets the host-side clock generator/poller run against real protocol timing in simulation.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on att_n, psx_clk and cmd (minimum 2).
- ACK_DELAY, 40, clk cycles from the 8th synchronised psx_clk rising edge until ack_n goes low.
- ACK_WIDTH, 20, clk cycles ack_n is held low.
- PAD_ID, 8'h41, byte returned in slot 1 (digital pad).

Ports:
- clk  in  1  system clock; psx_clk half-period is at least SYNC_STAGES+3 clk cycles.
- rst  in  1  reset, synchronous, active-high; clock clk.
- att_n  in  1  host attention, active low (asynchronous).
- psx_clk  in  1  host serial clock, idle high (asynchronous).
- cmd  in  1  host command bit (asynchronous).
- buttons  in  16  button state, active low (1 = released).
- dat_out  out  1  response bit.
- dat_oe  out  1  1 = drive dat_out; 0 = release the line (pulled high).
- ack_n  out  1  acknowledge, active low.
- cmd_byte  out  8  last fully received command byte.
- cmd_valid  out  1  one-cycle strobe when cmd_byte updates.
- byte_idx  out  4  index of the current byte in the transaction.
- busy  out  1  high while att_n is low and the pad is addressed.
- err_f  out  1  sticky protocol error; cleared at the next att_n falling edge.

Behaviour:
- Reset values: dat_out=1, dat_oe=0, ack_n=1, cmd_byte=0, cmd_valid=0, byte_idx=0, busy=0, err_f=0. All synchronizers preset to 1 (cmd to 0). State=IDLE.
- Edges are detected on the synchronised signals. All response latencies are counted from the synchronised edge, 1 cycle.
- Synchronised att_n high has priority in every state:
  - go to IDLE;
  - dat_oe=0, ack_n=1, busy=0;
  - bit and byte counters cleared.
- Response bytes, in order: 0: 8'hFF; 1: PAD_ID; 2: 8'h5A; 3: buttons[7:0]; 4: buttons[15:8]. LAST_IDX=4.
- buttons is snapshotted on the att_n falling edge and held for the whole transaction.
- State IDLE, on att_n falling:
  - load tx=8'hFF; dat_oe=1; dat_out=tx[0];
  - busy=1, byte_idx=0, bit_cnt=0, err_f=0;
  - go to SHIFT.
- State SHIFT:
  - psx_clk rising: rx = {cmd, rx[7:1]}; bit_cnt+1.
  - psx_clk falling with bit_cnt<8: tx shifts right, dat_out=next bit.
  - On the 8th rising edge: cmd_byte=received byte and cmd_valid=1 for one cycle.
  - If byte_idx==0 and the byte is not 8'h01: go to IGNORE (not addressed).
  - Else if byte_idx==LAST_IDX: go to DONE.
  - Else: go to ACK_WAIT.
- State ACK_WAIT:
  - wait ACK_DELAY cycles; the 8th falling edge is ignored here.
  - Then go to ACK_PULSE: ack_n=0 for ACK_WIDTH cycles.
  - At the end: ack_n=1, byte_idx+1, bit_cnt=0, load the next tx byte, dat_out=tx[0]; go to SHIFT.
- A psx_clk rising edge during ACK_WAIT or ACK_PULSE: err_f=1, ack_n=1, go to IGNORE.
- State DONE: on the next psx_clk falling edge, dat_oe=0. Stay until att_n high. No ACK is issued for the last byte.
- State IGNORE: dat_oe=0, ack_n=1, busy=0. Stay until att_n high.
- Extra psx_clk edges in DONE or IGNORE are ignored, and err_f is unchanged.
- att_n rising mid-byte or mid-ACK: abort immediately to IDLE, with no cmd_valid for the partial byte.
- Counter widths: bit_cnt 4 bits, saturating at 8; ACK counter sized for max(ACK_DELAY, ACK_WIDTH); byte_idx never exceeds LAST_IDX.

Optional Feature:
- PSX_ANALOG_EN defined:
  - adds ports stick_rx, stick_ry, stick_lx, stick_ly, each input, 8 bits;
  - slot-1 ID becomes 8'h73;
  - bytes 5..8 return rx, ry, lx, ly, snapshotted at att_n fall;
  - LAST_IDX=8, and ACKs follow bytes 0..7.
- Undefined: the stick ports are absent; digital 5-byte transaction with PAD_ID and LAST_IDX=4.

Test Plan:
- Poll 01,42,00,00,00 with buttons=16'hFFFE: DAT returns FF,41,5A,FE,FF; exactly 4 ack_n pulses, each ACK_WIDTH cycles low; cmd_valid fires 5 times with cmd_byte 01,42,00,00,00.
- First byte 8'h81: dat_oe=0 from byte end; no ack_n pulse; busy=0; err_f=0.
- att_n raised after 3 bits of byte 2: state IDLE and dat_oe=0 within SYNC_STAGES+1 cycles; no cmd_valid; the next poll completes normally.
- psx_clk rising 10 cycles into ACK_WAIT after byte 1: err_f=1, no ack_n pulse, dat released; err_f clears on the next att_n fall.
- buttons change from 16'hFFFF to 16'h0000 during byte 2: bytes 3 and 4 still read FF,FF.
- rst asserted during ACK_PULSE: next cycle ack_n=1, dat_oe=0, all outputs at reset values.
